// File: rtl/mul_share_sched.sv
// mul_share_sched
//
// Shares one pipelined 8x8 unsigned multiplier between NREQ operand
// requesters. A round-robin arbiter picks at most one requester per cycle and
// issues its operands straight to the multiplier. A tag pipeline records who
// owns each in-flight product. Products land in a result FIFO that feeds one
// AXI-Stream style output.
//
// Issue is gated by a credit counter that covers FIFO occupancy plus in-flight
// operations. The multiplier cannot stall, so every issued product is
// guaranteed a FIFO slot.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_en             issue enable (0 = drain: no new grants)
//   s_tvalid/s_tready  per-requester handshake, s_tready one-hot or zero
//   s_a, s_b           packed operands, requester i at [8i+7:8i]
//   mul_en/a/b         issue strobe and operands to the multiplier
//   mul_p/mul_valid    product and valid returning LAT cycles after mul_en
//   m_tvalid/m_tready  result handshake
//   m_tdata, m_tid     product and owning requester id
//   busy               an op is issuing, in flight, or queued
//   err                sticky: mul_valid disagreed with the tag pipeline
module mul_share_sched #(
  parameter int NREQ       = 4,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int IDW        = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_en,
  input  logic [NREQ-1:0]      s_tvalid,
  output logic [NREQ-1:0]      s_tready,
  input  logic [8*NREQ-1:0]    s_a,
  input  logic [8*NREQ-1:0]    s_b,
  output logic                 mul_en,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_p,
  input  logic                 mul_valid,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [15:0]          m_tdata,
  output logic [IDW-1:0]       m_tid,
  output logic                 busy,
  output logic                 err
);

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // (base + offs) mod NREQ for base, offs < NREQ: one subtraction is enough.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LAT-1:0]    tag_vld_q;
  logic [IDW-1:0]    tag_id_q [LAT];
  logic [PROD_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [IDW-1:0]    fifo_id_q [FIFO_DEPTH];
  logic              err_q;

  logic              win_found;
  logic [IDW-1:0]    win_id;
  logic              issue;
  logic              tag_out_vld;
  logic              fifo_wr;
  logic              fifo_rd;

  // Round-robin search: first valid requester at or above the pointer, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && s_tvalid[rr_idx(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_id    = rr_idx(rr_ptr_q, k);
      end
    end
  end

  // rst_n is in the term so that no grant escapes while reset is held, even
  // though the credit register already sits at its full reset value.
  assign issue = rst_n & cfg_en & (credit_q != '0) & win_found;

  always_comb begin
    s_tready = '0;
    mul_a    = '0;
    mul_b    = '0;
    if (issue) begin
      s_tready[win_id] = 1'b1;
      mul_a            = s_a[DATA_W*int'(win_id) +: DATA_W];
      mul_b            = s_b[DATA_W*int'(win_id) +: DATA_W];
    end
  end

  assign mul_en   = issue;
  assign rr_ptr_d = issue ? rr_idx(win_id, 1) : rr_ptr_q;

  assign tag_out_vld = tag_vld_q[LAT-1];
  // Capture follows the tag pipeline, not mul_valid, so ownership stays
  // consistent even when the multiplier misbehaves.
  assign fifo_wr     = tag_out_vld;
  assign m_tvalid    = (count_q != '0);
  assign fifo_rd     = m_tvalid & m_tready;

  // A pop returns its credit through the register, which keeps m_tready off
  // any combinational path to s_tready.
  always_comb begin
    credit_d = credit_q;
    case ({issue, fifo_rd})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: arbiter pointer, credits, FIFO pointers, tag pipeline, err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      credit_q  <= CW'(FIFO_DEPTH);
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      count_q  <= count_d;
      if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= win_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      if (mul_valid != tag_out_vld) err_q <= 1'b1;
    end
  end

  // Result storage. Cleared on reset so the head reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
    end else if (fifo_wr) begin
      fifo_data_q[wr_ptr_q] <= mul_p;
      fifo_id_q[wr_ptr_q]   <= tag_id_q[LAT-1];
    end
  end

  assign m_tdata = fifo_data_q[rd_ptr_q];
  assign m_tid   = fifo_id_q[rd_ptr_q];
  assign busy    = issue | (|tag_vld_q) | m_tvalid;
  assign err     = err_q;

endmodule

// File: doc/mul_share_sched.md
# mul_share_sched

Shared-resource scheduler for the pipelined 8-bit unsigned multiplier in the DSP accelerator. Accepts operand pairs from NREQ AXI-Stream-style requesters and picks one per cycle with a round-robin arbiter. Issues the winner to the multiplier, whose pipeline cannot stall, and tracks ownership of every in-flight product with a tag pipeline. Returns tagged products on one AXI-Stream output through a credit-protected result FIFO, so results are never lost under downstream backpressure.

## Interface
- NREQ, 4: number of requesters, 2..8
- LAT, 3: multiplier latency in cycles; mul_en high in cycle c → mul_valid and mul_p valid in cycle c+LAT
- FIFO_DEPTH, 8: result FIFO entries; must be ≥ LAT+2 for one-result-per-cycle throughput
- IDW, derived: max(1, ceil(log2(NREQ))), width of the requester id

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_en  in  1  issue enable; 0 = stop granting (drain mode)
- s_tvalid  in  NREQ  per-requester operand valid
- s_tready  out  NREQ  per-requester accept, one-hot or zero
- s_a  in  8*NREQ  operand A, requester i at bits [8i+7:8i]
- s_b  in  8*NREQ  operand B, same packing
- mul_en  out  1  issue strobe to multiplier
- mul_a, mul_b  out  8 each  operands to multiplier
- mul_p  in  16  product from multiplier
- mul_valid  in  1  multiplier output valid
- m_tvalid  out  1  result valid
- m_tready  in  1  downstream accept
- m_tdata  out  16  product
- m_tid  out  IDW  index of the owning requester
- busy  out  1  any op in flight or FIFO non-empty
- err  out  1  sticky; mul_valid disagreed with the tag pipeline

## Operation
- Reset values: s_tready=0, mul_en=0, mul_a=mul_b=0, m_tvalid=0, m_tdata=0, m_tid=0, busy=0, err=0. RR pointer=0, credits=FIFO_DEPTH, tag pipeline empty, FIFO empty.
- Credits:
  - credits = FIFO_DEPTH − FIFO occupancy − in-flight ops, held in a register.
  - An issue decrements credits; a FIFO pop (m_tvalid & m_tready) increments it.
  - Simultaneous issue and pop leaves credits unchanged.
  - A pop returns its credit on the next cycle. No same-cycle path from m_tready to s_tready.
- Issue condition: cfg_en & (credits>0) & |s_tvalid.
- Arbitration:
  - Winner is the first requester with s_tvalid=1, searching from the RR pointer upward with wrap.
  - s_tready[winner]=1 only when the issue condition holds.
  - On issue, the pointer moves to winner+1 mod NREQ. With no issue, the pointer holds.
- Issue datapath:
  - mul_en = issue; mul_a/mul_b = winner's operands.
  - When not issuing, mul_a/mul_b = 0.
  - All three are combinational from the registered state and the s_* inputs.
- Tag pipeline: LAT-deep shift register of {valid, id}. Loaded with {issue, winner} every cycle.
- Result capture:
  - When the tag-pipeline output valid is 1, write {mul_p, tag id} into the FIFO.
  - If mul_valid ≠ tag-pipeline output valid, set err. err clears only on reset. The write follows the tag pipeline.
- Output: m_tvalid = FIFO non-empty; m_tdata/m_tid = FIFO head, registered.
- FIFO:
  - Never overflows by construction of the credits.
  - Read and write in the same cycle are allowed when full or empty-after-write. An empty FIFO shows the written entry the next cycle; there is no bypass.
- cfg_en=0: no new grants. In-flight ops still complete and drain. busy falls once the pipeline and FIFO are empty.
- Reset mid-operation: all state clears immediately, including in-flight tags and FIFO contents. The multiplier shares rst_n and is flushed with the scheduler.
- Product arithmetic belongs to the multiplier: 16-bit unsigned, no truncation. The scheduler does not alter data.

## Timing
- Handshake accepted in cycle c (s_tvalid & s_tready): mul_en high in cycle c, FIFO write at the end of cycle c+LAT, m_tvalid high from cycle c+LAT+1. Minimum latency from accept to result is LAT+1 cycles.
- Sustained throughput with m_tready=1 and FIFO_DEPTH ≥ LAT+2: one accept per cycle.
- Results leave in issue order. Per-requester order is preserved.
- m_tvalid, once high, holds with stable data until m_tready=1.
- s_tready may drop without s_tvalid dropping. Requesters must hold their data while s_tvalid=1.
- With m_tready stuck low, exactly FIFO_DEPTH ops are accepted, then s_tready stays 0.

## Test plan
- Single request, r0: a=15, b=10, accepted in cycle c → m_tvalid in cycle c+4, m_tdata=150, m_tid=0. busy returns to 0 after the pop.
- All four requesters valid continuously, r0..r3 holding (255,1), (12,12), (200,3), (100,100) → grants r0,r1,r2,r3,r0… one per cycle. Outputs 255, 144, 600, 10000 repeat with matching m_tid.
- m_tready=0, r1 streaming 255×255 → exactly 8 accepts, then s_tready=0. Raising m_tready gives eight results of 65025, and accepts resume one cycle after the first pop.
- cfg_en dropped mid-stream after 3 accepts → no further s_tready. The 3 results (including 7×13=91) still appear, then busy=0.
- rst_n asserted with 2 ops in flight and 1 queued → all outputs 0 immediately. No stale results appear after release, and credits are back to 8.
- mul_valid forced low in the capture cycle of an issued op → err=1 and stays 1 until reset.
